// File: rtl/axi_single_beat_master.sv
// axi_single_beat_master
//   AXI4 initiator that turns a one-word request/response port into
//   single-beat AXI transactions (awlen/arlen = 0, INCR, full-width size).
//   Only one transaction is outstanding at a time.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid/req_ready          request handshake; req_we/addr/wdata/strb payload
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse, read data, error flag
//   aw*, w*, b*, ar*, r*         AXI4 master channels (bid/rid/rlast are ignored)
//
// Parameters
//   MST_ID       value driven on awid/arid
//   TIMEOUT_CYC  watchdog limit in cycles (AXI_MST_TIMEOUT_EN builds only)
//
// Build option
//   AXI_MST_TIMEOUT_EN  when defined, a per-state watchdog abandons a stalled
//                       transaction and reports it with rsp_err=1.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

module axi_single_beat_master #(
  parameter logic [`ID_BITS-1:0] MST_ID      = '0,
  parameter int unsigned         TIMEOUT_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [`ADDR_WIDTH-1:0]     req_addr,
  input  logic [`DATA_WIDTH-1:0]     req_wdata,
  input  logic [`DATA_WIDTH/8-1:0]   req_strb,
  output logic                       rsp_valid,
  output logic [`DATA_WIDTH-1:0]     rsp_rdata,
  output logic                       rsp_err,
  output logic [`ID_BITS-1:0]        awid,
  output logic [`ADDR_WIDTH-1:0]     awaddr,
  output logic [`LEN_BITS-1:0]       awlen,
  output logic [`SIZE_BITS-1:0]      awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [`DATA_WIDTH-1:0]     wdata,
  output logic [`DATA_WIDTH/8-1:0]   wstrb,
  output logic                       wvalid,
  output logic                       wlast,
  input  logic                       wready,
  input  logic [`ID_BITS-1:0]        bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  output logic [`ID_BITS-1:0]        arid,
  output logic [`ADDR_WIDTH-1:0]     araddr,
  output logic [`LEN_BITS-1:0]       arlen,
  output logic [1:0]                 arburst,
  output logic [`SIZE_BITS-1:0]      arsize,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [`ID_BITS-1:0]        rid,
  input  logic [`DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  input  logic                       rlast,
  output logic                       rready
);

  localparam logic [`SIZE_BITS-1:0] AXSIZE = `SIZE_BITS'($clog2(`DATA_WIDTH/8));

  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                     state_q, state_d;
  logic [`ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [`DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [`DATA_WIDTH/8-1:0]   strb_q, strb_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [`DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

`ifdef AXI_MST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

  // Single outstanding transaction: IDs, rlast and the low resp bit carry no information.
  logic unused_in;
  assign unused_in = ^{bid, rid, rlast, bresp[0], rresp[0]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXI_MST_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next state and datapath
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d    = req_addr;
        wdata_d   = req_wdata;
        strb_d    = req_strb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = req_we ? WRITE : RD_ADDR;
      end
      WRITE: begin
        // AW and W complete independently; a done channel ignores its ready.
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (bvalid) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = bresp[1];
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: if (rvalid) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = rresp[1];
        rsp_rdata_d = rdata;
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_MST_TIMEOUT_EN
    // Fires only when this cycle makes no state progress; a handshake landing
    // on the last allowed cycle still wins.
    if (state_q != IDLE && state_d == state_q && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
    cnt_d = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
`endif
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == IDLE);
    awvalid   = (state_q == WRITE) && !aw_done_q;
    wvalid    = (state_q == WRITE) && !w_done_q;
    wlast     = wvalid;
    bready    = (state_q == WR_RESP);
    arvalid   = (state_q == RD_ADDR);
    rready    = (state_q == RD_DATA);
  end

  assign awid      = MST_ID;
  assign awaddr    = addr_q;
  assign awlen     = '0;
  assign awsize    = AXSIZE;
  assign awburst   = 2'b01;
  assign wdata     = wdata_q;
  assign wstrb     = strb_q;
  assign arid      = MST_ID;
  assign araddr    = addr_q;
  assign arlen     = '0;
  assign arsize    = AXSIZE;
  assign arburst   = 2'b01;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Bench for axi_single_beat_master: directed requests against a delay-configurable
// AXI slave model; a transaction-level model predicts each response and its latency.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

module tb_axi_single_beat_master;
  localparam logic [3:0] MID = 4'h3;
  localparam int TMO = 16;
`ifdef AXI_MST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_strb;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rlast, rready;

  always #5 clk = ~clk;

  axi_single_beat_master #(.MST_ID(MID), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  // slave configuration
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  logic cfg_rlast;
  // slave state
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit aw_seen, w_seen, b_pend, r_pend;

  // transaction model
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    logic [11:0] beats;   // {aw, w, ar} beat counts
  } exp_t;
  exp_t expq[$];
  bit busy;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0] exp_strb;
  int n_aw, n_w, n_ar;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  bit accepted, rsp_seen;
  logic [31:0] last_rdata;
  logic last_err;
  int last_lat;
  // previous-cycle view for the hold rules
  bit p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_rst;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_slv(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd,
                         input logic rl);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd; cfg_rlast = rl;
  endtask

  // One clock: predict handshakes of the coming edge, cross it, check outputs,
  // then drive slave inputs for the next edge.
  task automatic cycle();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    exp_t e;
    int mx;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    accepted = 0;
    if (rst) begin
      expq.delete();
      busy = 0; aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
    end else begin
      if (req_valid && req_ready) begin
        accepted = 1; busy = 1; n_aw = 0; n_w = 0; n_ar = 0;
        exp_addr = req_addr; exp_wdata = req_wdata; exp_strb = req_strb;
        e.acc = cyc;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        if (req_we) begin
          e.rdata = '0; e.err = cfg_bresp[1]; e.lat = 3 + mx + b_dly; e.beats = 12'h110;
        end else if (TMO_EN && ar_dly >= TMO) begin
          e.rdata = '0; e.err = 1'b1; e.lat = 1 + TMO; e.beats = 12'h000;
        end else begin
          e.rdata = cfg_rdata; e.err = cfg_rresp[1]; e.lat = 3 + ar_dly + r_dly; e.beats = 12'h001;
        end
        expq.push_back(e);
      end
      if (aw_hs) begin n_aw++; got_awaddr = awaddr; aw_seen = 1; end
      if (w_hs)  begin n_w++;  got_wdata  = wdata;  w_seen  = 1; end
      if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_wait = 0; end
      if (b_hs) b_pend = 0;
      if (ar_hs) begin n_ar++; got_araddr = araddr; r_pend = 1; r_wait = 0; end
      if (r_hs) r_pend = 0;
    end
    p_awv = awvalid; p_aw_hs = aw_hs; p_awaddr = awaddr;
    p_wv = wvalid; p_w_hs = w_hs; p_wdata = wdata;
    p_arv = arvalid; p_ar_hs = ar_hs; p_araddr = araddr;
    p_rst = rst;

    @(negedge clk);
    cyc++;

    rsp_seen = 0;
    if (rsp_valid) begin
      rsp_seen = 1;
      if (expq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no transaction outstanding (cycle %0d)", cyc);
      end else begin
        e = expq.pop_front();
        busy = 0;
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        check("beat_counts", 64'({n_aw[3:0], n_w[3:0], n_ar[3:0]}), 64'(e.beats));
        last_rdata = rsp_rdata; last_err = rsp_err; last_lat = cyc - e.acc;
      end
    end
    check("req_ready", 64'(req_ready), 64'(!busy));
    if (!p_rst && p_awv && !p_aw_hs) begin
      check("awvalid_hold", 64'(awvalid), 64'(1));
      check("awaddr_stable", 64'(awaddr), 64'(p_awaddr));
    end
    if (!p_rst && p_wv && !p_w_hs) begin
      check("wvalid_hold", 64'(wvalid), 64'(1));
      check("wdata_stable", 64'(wdata), 64'(p_wdata));
    end
    if (!p_rst && p_arv && !p_ar_hs) begin
      check("arvalid_hold", 64'(arvalid), 64'(1));
      check("araddr_stable", 64'(araddr), 64'(p_araddr));
    end
    if (awvalid)
      check("aw_fields", 64'({awid, awlen, awsize, awburst, awaddr}),
            64'({MID, 8'd0, 3'd2, 2'b01, exp_addr}));
    if (wvalid)
      check("w_fields", 64'({wlast, wstrb, wdata}), 64'({1'b1, exp_strb, exp_wdata}));
    if (arvalid)
      check("ar_fields", 64'({arid, arlen, arsize, arburst, araddr}),
            64'({MID, 8'd0, 3'd2, 2'b01, exp_addr}));

    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin awready = 0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
      else begin wready = 0; w_wait = 0; end
      if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin arready = 0; ar_wait = 0; end
      if (b_pend) begin bvalid = (b_wait >= b_dly); b_wait++; end
      else bvalid = 0;
      if (r_pend) begin rvalid = (r_wait >= r_dly); r_wait++; end
      else rvalid = 0;
    end
    bresp = cfg_bresp; bid = 4'h5;
    rresp = cfg_rresp; rid = 4'ha; rlast = cfg_rlast;
    rdata = rvalid ? cfg_rdata : 32'h0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int g;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_strb = s;
    g = 0;
    accepted = 0;
    while (!accepted && g < 20) begin cycle(); g++; end
    if (!accepted) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: req_ready never seen for addr 0x%0h", a);
    end
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int budget);
    int g;
    g = 0;
    rsp_seen = 0;
    while (!rsp_seen && g < budget) begin cycle(); g++; end
    if (!rsp_seen) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bid = 0; bresp = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    busy = 0;
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    cycle(); cycle();
    // reset state
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    check("rst_regs", 64'({awaddr, wdata}), 64'(0));
    rst = 0;
    cycle();

    // 1: zero-wait write; rsp_valid in the 4th cycle counting the accept cycle
    do_req(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(20);
    check("t1_awaddr", 64'(got_awaddr), 64'(32'h4));
    check("t1_wdata", 64'(got_wdata), 64'(32'hDEAD_BEEF));
    check("t1_latency", 64'(last_lat), 64'(3));
    check("t1_err", 64'(last_err), 64'(0));

    // 2: W accepted 3 cycles before AW
    set_slv(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    do_req(1, 32'h0000_0010, 32'hA5A5_0F0F, 4'h3);
    cycle();
    check("t2_wvalid_dropped", 64'(wvalid), 64'(0));
    check("t2_awvalid_held", 64'(awvalid), 64'(1));
    wait_rsp(20);
    check("t2_latency", 64'(last_lat), 64'(6));

    // 2b: AW first, W two cycles later, one-cycle B delay
    set_slv(0, 2, 1, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    do_req(1, 32'h0000_0020, 32'h0BAD_F00D, 4'hC);
    wait_rsp(20);
    check("t2b_latency", 64'(last_lat), 64'(6));

    // 3: read with 2-cycle rvalid delay, back-to-back after the write response
    set_slv(0, 0, 0, 0, 2, 2'b00, 2'b00, 32'h1234_5678, 1'b1);
    do_req(0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(20);
    check("t3_araddr", 64'(got_araddr), 64'(32'h8));
    check("t3_rdata", 64'(last_rdata), 64'(32'h1234_5678));
    check("t3_err", 64'(last_err), 64'(0));
    check("t3_latency", 64'(last_lat), 64'(5));

    // 4: SLVERR read (rlast=0 still final), DECERR write
    set_slv(0, 0, 0, 1, 0, 2'b00, 2'b10, 32'hCAFE_F00D, 1'b0);
    do_req(0, 32'h0000_000C, 32'h0, 4'h0);
    wait_rsp(20);
    check("t4_rd_err", 64'(last_err), 64'(1));
    check("t4_rd_rdata", 64'(last_rdata), 64'(32'hCAFE_F00D));
    set_slv(0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0, 1'b1);
    do_req(1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
    wait_rsp(20);
    check("t4_wr_err", 64'(last_err), 64'(1));
    check("t4_wr_rdata", 64'(last_rdata), 64'(0));

    // 5: reset while awvalid is high
    set_slv(10, 10, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    do_req(1, 32'h0000_0040, 32'h1111_2222, 4'hF);
    check("t5_awvalid_before", 64'(awvalid), 64'(1));
    rst = 1;
    cycle();
    check("t5_valids_cleared", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
    check("t5_no_rsp", 64'(rsp_valid), 64'(0));
    check("t5_req_ready", 64'(req_ready), 64'(1));
    rst = 0;
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle();

    // 7: clean zero-wait read after the abandoned write
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8765_4321, 1'b1);
    do_req(0, 32'h0000_0044, 32'h0, 4'h0);
    wait_rsp(20);
    check("t7_rdata", 64'(last_rdata), 64'(32'h8765_4321));
    check("t7_latency", 64'(last_lat), 64'(3));

`ifdef AXI_MST_TIMEOUT_EN
    // 6: arready never comes; watchdog ends the read 16 cycles after RD_ADDR entry
    set_slv(0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    do_req(0, 32'h0000_0050, 32'h0, 4'h0);
    wait_rsp(40);
    check("t6_latency", 64'(last_lat), 64'(17));
    check("t6_err", 64'(last_err), 64'(1));
    check("t6_arvalid_dropped", 64'(arvalid), 64'(0));
    set_slv(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 1'b1);
    cycle();
`endif

    for (int i = 0; i < 3; i++) cycle();
    check("no_outstanding", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
